mux_2to1: RTL and testbench



---
 rtl/mux_2to1.sv | 61 ++++++
 tb/tb_mux_2to1.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
`default_nettype none
// ============================================================================
// Module      : mux_2to1
// Description : Registered 2:1 selector with a STAGES-deep output pipeline and
//               a source-change flag (SWITCHED) aligned with OUT.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2to1 #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] OUT,
    output logic             SWITCHED
);

    // Reject out-of-range configurations at elaboration time.
    generate
        if ((WIDTH < 1) || (WIDTH > 64)) begin : g_bad_width
            $error("mux_2to1: WIDTH must be in 1..64");
        end
        if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
            $error("mux_2to1: STAGES must be in 1..4");
        end
    endgenerate

    logic [WIDTH-1:0]             w_sel_data;
    logic                         w_switch;
    logic [STAGES-1:0][WIDTH-1:0] r_data;
    logic [STAGES-1:0]            r_sw;
    logic                         r_sel_hist;

    assign w_sel_data = SEL ? B : A;
    assign w_switch   = SEL ^ r_sel_hist;

    // Reset wins over capture; the history restarts at source A.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data     <= '0;
            r_sw       <= '0;
            r_sel_hist <= 1'b0;
        end else begin
            r_data[0]  <= w_sel_data;
            r_sw[0]    <= w_switch;
            for (int i = 1; i < STAGES; i++) begin
                r_data[i] <= r_data[i-1];
                r_sw[i]   <= r_sw[i-1];
            end
            r_sel_hist <= SEL;
        end
    end

    assign OUT      = r_data[STAGES-1];
    assign SWITCHED = r_sw[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1.sv
`default_nettype none
// Bench for mux_2to1: three configurations share one stimulus stream and are
// compared each cycle against a history-based reference model.
module tb_mux_2to1;

    logic       clk;
    logic       rst;
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;

    logic [0:0] out_s1;
    logic       sw_s1;
    logic [7:0] out_s3;
    logic       sw_s3;
    logic [7:0] out_s4;
    logic       sw_s4;

    int n_checks;
    int n_fail;
    int t_edge;

    bit         rst_q[$];
    bit         sel_q[$];
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];

    mux_2to1 #(.WIDTH(1), .STAGES(1)) u_w1s1 (
        .CLK(clk), .RST(rst), .SEL(sel), .A(a[0:0]), .B(b[0:0]),
        .OUT(out_s1), .SWITCHED(sw_s1)
    );

    mux_2to1 #(.WIDTH(8), .STAGES(3)) u_w8s3 (
        .CLK(clk), .RST(rst), .SEL(sel), .A(a), .B(b),
        .OUT(out_s3), .SWITCHED(sw_s3)
    );

    mux_2to1 #(.WIDTH(8), .STAGES(4)) u_w8s4 (
        .CLK(clk), .RST(rst), .SEL(sel), .A(a), .B(b),
        .OUT(out_s4), .SWITCHED(sw_s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d: got %0h expected %0h", tag, t_edge, obs, exp);
        end
    endtask

    // The word visible after edge t was captured at edge t-s+1; any reset
    // between capture and now means the output is still zero.
    function automatic bit flushed(int s, int t);
        int c = t - s + 1;
        if (c < 0) return 1'b1;
        for (int k = c; k <= t; k++)
            if (rst_q[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] exp_out(int s, int t, logic [63:0] mask);
        int c = t - s + 1;
        if (flushed(s, t)) return 64'd0;
        return (sel_q[c] ? {56'd0, b_q[c]} : {56'd0, a_q[c]}) & mask;
    endfunction

    function automatic logic [63:0] exp_sw(int s, int t);
        int c = t - s + 1;
        bit prev;
        if (flushed(s, t)) return 64'd0;
        prev = (c == 0 || rst_q[c-1]) ? 1'b0 : sel_q[c-1];
        return {63'd0, sel_q[c] ^ prev};
    endfunction

    task automatic tick();
        @(posedge clk);
        rst_q.push_back(rst);
        sel_q.push_back(sel);
        a_q.push_back(a);
        b_q.push_back(b);
        #1;
        check("s1_out", {63'd0, out_s1}, exp_out(1, t_edge, 64'h1));
        check("s1_sw",  {63'd0, sw_s1},  exp_sw(1, t_edge));
        check("s3_out", {56'd0, out_s3}, exp_out(3, t_edge, 64'hFF));
        check("s3_sw",  {63'd0, sw_s3},  exp_sw(3, t_edge));
        check("s4_out", {56'd0, out_s4}, exp_out(4, t_edge, 64'hFF));
        check("s4_sw",  {63'd0, sw_s4},  exp_sw(4, t_edge));
        t_edge++;
    endtask

    task automatic drive(input bit r, input bit s, input logic [7:0] va, input logic [7:0] vb);
        rst = r;
        sel = s;
        a   = va;
        b   = vb;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        t_edge   = 0;
        rst = 1'b1; sel = 1'b1; a = 8'h01; b = 8'h01;

        // Reset with all inputs high, then release and let the ones emerge.
        drive(1, 1, 8'h01, 8'h01);
        drive(1, 1, 8'h01, 8'h01);
        check("rst_out_s4", {56'd0, out_s4}, 64'd0);
        for (int i = 0; i < 5; i++) drive(0, 1, 8'h01, 8'h01);
        check("post_rst_s4", {56'd0, out_s4}, 64'h01);

        // Truth table over SEL/A/B.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            drive(0, v[2], {7'd0, v[1]}, {7'd0, v[0]});
        end

        // Wide data, held for the deepest pipeline to show both sources.
        for (int i = 0; i < 5; i++) drive(0, 0, 8'hA5, 8'h3C);
        check("wide_a", {56'd0, out_s4}, 64'hA5);
        for (int i = 0; i < 5; i++) drive(0, 1, 8'hA5, 8'h3C);
        check("wide_b", {56'd0, out_s4}, 64'h3C);

        // Select toggling every cycle.
        for (int i = 0; i < 8; i++) drive(0, i[0], 8'h00, 8'h01);
        check("toggle_sw_s4", {63'd0, sw_s4}, 64'd1);

        // Mid-operation reset with the pipeline full of ones.
        for (int i = 0; i < 5; i++) drive(0, 1, 8'hFF, 8'hFF);
        drive(1, 1, 8'hFF, 8'hFF);
        check("midrst_s4", {56'd0, out_s4}, 64'd0);
        for (int i = 0; i < 6; i++) drive(0, 1, 8'hFF, 8'hFF);
        check("midrst_fresh_s4", {56'd0, out_s4}, 64'hFF);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                  8'($urandom), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
